// File: rtl/riscv_pkg.sv
`default_nettype none
//==============================================================================
// Module      : riscv_pkg
// Description : Shared RV64I decode types, opcode constants and immediate helper.
// Revision    : 1.0 - initial release
//==============================================================================
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } aluop_t;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   alusrc;
    logic   branch;
    aluop_t aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{
    regwrite: 1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    memtoreg: 1'b0,
    alusrc:   1'b0,
    branch:   1'b0,
    aluop:    ALU_ADD
  };

  // Immediate format follows the opcode; R-type and unknown opcodes yield zero.
  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] instr);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (instr[6:0])
      OP_IALU, OP_LOAD:
        imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OP_STORE:
        imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
               instr[11:8], 1'b0};
      default:
        imm = '0;
    endcase
    return imm;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_32x64.sv
`default_nettype none
//==============================================================================
// Module      : reg_file_32x64
// Description : Register file, two async read ports, one sync write, x0 = 0.
//               ID_WB_BYPASS_EN enables write-through on same-cycle read/write.
// Revision    : 1.0 - initial release
//==============================================================================
module reg_file_32x64 #(
  parameter int  XLEN = 64,
  parameter int  NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data
);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_wr_en;

  assign w_wr_en = i_we && (i_wr_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    o_rs1_data = r_regs[i_rs1_addr];
    o_rs2_data = r_regs[i_rs2_addr];
`ifdef ID_WB_BYPASS_EN
    if (w_wr_en && (i_wr_addr == i_rs1_addr)) o_rs1_data = i_wr_data;
    if (w_wr_en && (i_wr_addr == i_rs2_addr)) o_rs2_data = i_wr_data;
`endif
    if (i_rs1_addr == '0) o_rs1_data = '0;
    if (i_rs2_addr == '0) o_rs2_data = '0;
  end

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
//==============================================================================
// Module      : id_stage
// Description : RV64I decode stage: IF/ID latch, decode, regfile, load-use
//               hazard, registered ID/EX bundle. Option: ID_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module id_stage #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_if_valid,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic [31:0]     i_if_instr,
  input  logic            i_flush,
  input  logic            i_wb_we,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_stall_if,
  output logic            o_id_valid,
  output logic [XLEN-1:0] o_id_pc,
  output logic [XLEN-1:0] o_id_rs1_data,
  output logic [XLEN-1:0] o_id_rs2_data,
  output logic [XLEN-1:0] o_id_imm,
  output logic [4:0]      o_id_rs1,
  output logic [4:0]      o_id_rs2,
  output logic [4:0]      o_id_rd,
  output logic [2:0]      o_id_funct3,
  output logic            o_id_funct7b5,
  output logic            o_id_regwrite,
  output logic            o_id_memread,
  output logic            o_id_memwrite,
  output logic            o_id_memtoreg,
  output logic            o_id_alusrc,
  output logic            o_id_branch,
  output logic [1:0]      o_id_aluop,
  output logic            o_id_illegal
);

  import riscv_pkg::*;

  logic            r_ifid_valid;
  logic [XLEN-1:0] r_ifid_pc;
  logic [31:0]     r_ifid_instr;

  logic            r_idex_valid;
  logic [XLEN-1:0] r_idex_pc;
  logic [XLEN-1:0] r_idex_rs1_data;
  logic [XLEN-1:0] r_idex_rs2_data;
  logic [XLEN-1:0] r_idex_imm;
  logic [4:0]      r_idex_rs1;
  logic [4:0]      r_idex_rs2;
  logic [4:0]      r_idex_rd;
  logic [2:0]      r_idex_funct3;
  logic            r_idex_funct7b5;
  ctrl_t           r_idex_ctrl;
  logic            r_idex_illegal;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  ctrl_t           w_ctrl;
  logic            w_illegal;
  logic            w_uses_rs2;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic            w_hazard;
  logic            w_bubble;

  assign w_opcode = r_ifid_instr[6:0];
  assign w_rd     = r_ifid_instr[11:7];
  assign w_rs1    = r_ifid_instr[19:15];
  assign w_rs2    = r_ifid_instr[24:20];
  assign w_imm    = imm_gen(r_ifid_instr);

  always_comb begin
    w_ctrl     = CTRL_NONE;
    w_illegal  = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.aluop    = ALU_RTYPE;
        w_uses_rs2      = 1'b1;
      end
      OP_IALU: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.aluop    = ALU_ITYPE;
      end
      OP_LOAD: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memread  = 1'b1;
        w_ctrl.memtoreg = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.aluop    = ALU_ADD;
      end
      OP_STORE: begin
        w_ctrl.memwrite = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.aluop    = ALU_ADD;
        w_uses_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.aluop  = ALU_BRANCH;
        w_uses_rs2    = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  reg_file_32x64 #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_reg_file (
    .clk        (clk),
    .reset      (reset),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_we       (i_wb_we),
    .i_wr_addr  (i_wb_rd),
    .i_wr_data  (i_wb_data)
  );

  // A load in ID/EX whose destination is consumed by the instruction in IF/ID.
  assign w_hazard = r_idex_valid && r_idex_ctrl.memread && (r_idex_rd != 5'd0) &&
                    ((r_idex_rd == w_rs1) || ((r_idex_rd == w_rs2) && w_uses_rs2)) &&
                    r_ifid_valid;

  assign o_stall_if = w_hazard && !i_flush && !reset;
  assign w_bubble   = i_flush || w_hazard || !r_ifid_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= '0;
    end else if (i_flush) begin
      r_ifid_valid <= 1'b0;
    end else if (!w_hazard) begin
      r_ifid_valid <= i_if_valid;
      r_ifid_pc    <= i_if_pc;
      r_ifid_instr <= i_if_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_bubble) begin
      r_idex_valid    <= 1'b0;
      r_idex_pc       <= '0;
      r_idex_rs1_data <= '0;
      r_idex_rs2_data <= '0;
      r_idex_imm      <= '0;
      r_idex_rs1      <= '0;
      r_idex_rs2      <= '0;
      r_idex_rd       <= '0;
      r_idex_funct3   <= '0;
      r_idex_funct7b5 <= 1'b0;
      r_idex_ctrl     <= CTRL_NONE;
      r_idex_illegal  <= 1'b0;
    end else begin
      r_idex_valid    <= 1'b1;
      r_idex_pc       <= r_ifid_pc;
      r_idex_rs1_data <= w_rs1_data;
      r_idex_rs2_data <= w_rs2_data;
      r_idex_imm      <= w_imm;
      r_idex_rs1      <= w_rs1;
      r_idex_rs2      <= w_rs2;
      r_idex_rd       <= w_rd;
      r_idex_funct3   <= r_ifid_instr[14:12];
      r_idex_funct7b5 <= r_ifid_instr[30];
      r_idex_ctrl     <= w_ctrl;
      r_idex_illegal  <= w_illegal;
    end
  end

  assign o_id_valid    = r_idex_valid;
  assign o_id_pc       = r_idex_pc;
  assign o_id_rs1_data = r_idex_rs1_data;
  assign o_id_rs2_data = r_idex_rs2_data;
  assign o_id_imm      = r_idex_imm;
  assign o_id_rs1      = r_idex_rs1;
  assign o_id_rs2      = r_idex_rs2;
  assign o_id_rd       = r_idex_rd;
  assign o_id_funct3   = r_idex_funct3;
  assign o_id_funct7b5 = r_idex_funct7b5;
  assign o_id_regwrite = r_idex_ctrl.regwrite;
  assign o_id_memread  = r_idex_ctrl.memread;
  assign o_id_memwrite = r_idex_ctrl.memwrite;
  assign o_id_memtoreg = r_idex_ctrl.memtoreg;
  assign o_id_alusrc   = r_idex_ctrl.alusrc;
  assign o_id_branch   = r_idex_ctrl.branch;
  assign o_id_aluop    = r_idex_ctrl.aluop;
  assign o_id_illegal  = r_idex_illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
//==============================================================================
// Module      : tb_id_stage
// Description : Self-checking bench for id_stage (vector table, directed
//               sequences, random stimulus against a reference model).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_id_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        i_if_valid;
  logic [63:0] i_if_pc;
  logic [31:0] i_if_instr;
  logic        i_flush;
  logic        i_wb_we;
  logic [4:0]  i_wb_rd;
  logic [63:0] i_wb_data;
  logic        o_stall_if, o_id_valid, o_id_funct7b5, o_id_illegal;
  logic [63:0] o_id_pc, o_id_rs1_data, o_id_rs2_data, o_id_imm;
  logic [4:0]  o_id_rs1, o_id_rs2, o_id_rd;
  logic [2:0]  o_id_funct3;
  logic        o_id_regwrite, o_id_memread, o_id_memwrite, o_id_memtoreg;
  logic        o_id_alusrc, o_id_branch;
  logic [1:0]  o_id_aluop;
  logic [7:0]  act_ctrl;

  assign act_ctrl = {o_id_regwrite, o_id_memread, o_id_memwrite, o_id_memtoreg,
                     o_id_alusrc, o_id_branch, o_id_aluop};

  id_stage dut (
    .clk(clk), .reset(reset),
    .i_if_valid(i_if_valid), .i_if_pc(i_if_pc), .i_if_instr(i_if_instr),
    .i_flush(i_flush), .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_stall_if(o_stall_if), .o_id_valid(o_id_valid), .o_id_pc(o_id_pc),
    .o_id_rs1_data(o_id_rs1_data), .o_id_rs2_data(o_id_rs2_data), .o_id_imm(o_id_imm),
    .o_id_rs1(o_id_rs1), .o_id_rs2(o_id_rs2), .o_id_rd(o_id_rd),
    .o_id_funct3(o_id_funct3), .o_id_funct7b5(o_id_funct7b5),
    .o_id_regwrite(o_id_regwrite), .o_id_memread(o_id_memread),
    .o_id_memwrite(o_id_memwrite), .o_id_memtoreg(o_id_memtoreg),
    .o_id_alusrc(o_id_alusrc), .o_id_branch(o_id_branch),
    .o_id_aluop(o_id_aluop), .o_id_illegal(o_id_illegal)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        valid;
    logic [63:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [7:0]  ctrl;   // {regwrite,memread,memwrite,memtoreg,alusrc,branch,aluop}
    logic        ill;
  } bun_t;

  logic [63:0] m_regs [32];
  logic        m_if_v;
  logic [63:0] m_if_pc;
  logic [31:0] m_if_instr;
  bun_t        m_ex;
  int          m_kind;   // 0 issued, 1 stall/flush bubble, 2 empty slot, 3 reset

  function automatic logic [7:0] ref_ctrl(input logic [6:0] op);
    case (op)
      7'h33:   return 8'h82;
      7'h13:   return 8'h8B;
      7'h03:   return 8'hD8;
      7'h23:   return 8'h28;
      7'h63:   return 8'h05;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic ref_legal(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
  endfunction

  function automatic logic ref_uses_rs2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] ins);
    logic [11:0] i12;
    logic [11:0] s12;
    logic [12:0] b13;
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    case (ins[6:0])
      7'h13, 7'h03: return 64'(longint'($signed(i12)));
      7'h23:        return 64'(longint'($signed(s12)));
      7'h63:        return 64'(longint'($signed(b13)));
      default:      return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 64'd0;
`ifdef ID_WB_BYPASS_EN
    if (i_wb_we && i_wb_rd == idx) return i_wb_data;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic model_stall();
    logic [4:0] s1;
    logic [4:0] s2;
    s1 = m_if_instr[19:15];
    s2 = m_if_instr[24:20];
    return !reset && !i_flush && m_if_v && m_ex.valid && m_ex.ctrl[6] && (m_ex.rd != 5'd0) &&
           ((m_ex.rd == s1) || ((m_ex.rd == s2) && ref_uses_rs2(m_if_instr[6:0])));
  endfunction

  task automatic model_edge();
    bun_t nb;
    logic st;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      m_if_v = 1'b0; m_if_pc = 64'd0; m_if_instr = 32'd0;
      m_ex = '0; m_kind = 3;
      return;
    end
    st = model_stall();
    nb = '0;
    if (i_flush || st) m_kind = 1;
    else if (!m_if_v)  m_kind = 2;
    else begin
      m_kind   = 0;
      nb.valid = 1'b1;
      nb.pc    = m_if_pc;
      nb.rs1   = m_if_instr[19:15];
      nb.rs2   = m_if_instr[24:20];
      nb.rd    = m_if_instr[11:7];
      nb.d1    = ref_read(nb.rs1);
      nb.d2    = ref_read(nb.rs2);
      nb.imm   = ref_imm(m_if_instr);
      nb.f3    = m_if_instr[14:12];
      nb.f7    = m_if_instr[30];
      nb.ctrl  = ref_ctrl(m_if_instr[6:0]);
      nb.ill   = !ref_legal(m_if_instr[6:0]);
    end
    if (i_wb_we && i_wb_rd != 5'd0) m_regs[i_wb_rd] = i_wb_data;
    if (i_flush) m_if_v = 1'b0;
    else if (!st) begin
      m_if_v = i_if_valid; m_if_pc = i_if_pc; m_if_instr = i_if_instr;
    end
    m_ex = nb;
  endtask

  task automatic check_outputs();
    chk("id_valid", o_id_valid, m_ex.valid);
    if (m_kind != 2) chk("ctrl", act_ctrl, m_ex.ctrl);
    if (m_kind == 0 || m_kind == 3) begin
      chk("id_pc", o_id_pc, m_ex.pc);
      chk("rs1_data", o_id_rs1_data, m_ex.d1);
      chk("rs2_data", o_id_rs2_data, m_ex.d2);
      chk("imm", o_id_imm, m_ex.imm);
      chk("rs1_rs2_rd", {o_id_rs1, o_id_rs2, o_id_rd}, {m_ex.rs1, m_ex.rs2, m_ex.rd});
      chk("funct", {o_id_funct3, o_id_funct7b5}, {m_ex.f3, m_ex.f7});
      chk("illegal", o_id_illegal, m_ex.ill);
    end
  endtask

  // One clock: check the combinational stall, advance model and DUT, check bundle.
  task automatic tick();
    #1;
    chk("stall_if", o_stall_if, model_stall());
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    i_if_valid = 1'b0; i_if_pc = 64'd0; i_if_instr = 32'd0;
    i_flush = 1'b0; i_wb_we = 1'b0; i_wb_rd = 5'd0; i_wb_data = 64'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic present(input logic [31:0] ins, input logic [63:0] pc);
    i_if_valid = 1'b1; i_if_instr = ins; i_if_pc = pc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] op;
    case ($urandom_range(0, 6))
      0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h23;
      4: op = 7'h63; 5: op = 7'h7F; default: op = 7'h37;
    endcase
    return {7'($urandom), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
            3'($urandom), 5'($urandom_range(0, 4)), op};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [7:0]  ctrl;
    logic        ill;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{32'h00500093, 64'd5,                  8'h8B, 1'b0, 5'd1,  5'd1, 5'd0,  3'd0};
    vt[1] = '{32'hFE112C23, 64'hFFFFFFFFFFFFFFF8,   8'h28, 1'b0, 5'd24, 5'd2, 5'd1,  3'd2};
    vt[2] = '{32'h0000A103, 64'd0,                  8'hD8, 1'b0, 5'd2,  5'd1, 5'd0,  3'd2};
    vt[3] = '{32'h002101B3, 64'd0,                  8'h82, 1'b0, 5'd3,  5'd2, 5'd2,  3'd0};
    vt[4] = '{32'h00208463, 64'd8,                  8'h05, 1'b0, 5'd8,  5'd1, 5'd2,  3'd0};
    vt[5] = '{32'hFE0018E3, 64'hFFFFFFFFFFFFFFF0,   8'h05, 1'b0, 5'd17, 5'd0, 5'd0,  3'd1};
    vt[6] = '{32'hFFF30293, 64'hFFFFFFFFFFFFFFFF,   8'h8B, 1'b0, 5'd5,  5'd6, 5'd31, 3'd0};
    vt[7] = '{32'h0000007F, 64'd0,                  8'h00, 1'b1, 5'd0,  5'd0, 5'd0,  3'd0};
    // vt[0] rs1/rs2 fields: addi x1,x0,5 has rs1=0, rs2 field=5
    vt[0].rs1 = 5'd0;
    vt[0].rs2 = 5'd5;

    idle_inputs();
    reset = 1'b1;
    tick();
    chk("reset_stall", o_stall_if, 1'b0);
    chk("reset_valid", o_id_valid, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      present(vt[i].instr, 64'h1000 + 64'(4 * i));
      tick();
      i_if_valid = 1'b0;
      tick();
      chk("tbl_valid", o_id_valid, 1'b1);
      chk("tbl_imm", o_id_imm, vt[i].imm);
      chk("tbl_ctrl", act_ctrl, vt[i].ctrl);
      chk("tbl_illegal", o_id_illegal, vt[i].ill);
      chk("tbl_rd", o_id_rd, vt[i].rd);
      chk("tbl_rs1", o_id_rs1, vt[i].rs1);
      chk("tbl_rs2", o_id_rs2, vt[i].rs2);
      chk("tbl_funct3", o_id_funct3, vt[i].f3);
      chk("tbl_pc", o_id_pc, 64'h1000 + 64'(4 * i));
    end

    // Same-cycle writeback of x5 while IF/ID reads x5.
    do_reset();
    present(32'h00028313, 64'h2000);
    tick();
    i_if_valid = 1'b0;
    i_wb_we = 1'b1; i_wb_rd = 5'd5; i_wb_data = 64'hDEAD;
    tick();
`ifdef ID_WB_BYPASS_EN
    chk("bypass_rs1", o_id_rs1_data, 64'hDEAD);
`else
    chk("bypass_rs1", o_id_rs1_data, 64'h0);
`endif
    i_wb_we = 1'b0;
    present(32'h00028313, 64'h2004);
    tick();
    i_if_valid = 1'b0;
    tick();
    chk("x5_written", o_id_rs1_data, 64'hDEAD);

    // Load-use: lw x2,0(x1); add x3,x2,x2
    do_reset();
    present(32'h0000A103, 64'h3000);
    tick();
    present(32'h002101B3, 64'h3004);
    tick();
    chk("lu_stall_on", o_stall_if, 1'b1);
    tick();
    chk("lu_bubble", o_id_valid, 1'b0);
    chk("lu_stall_off", o_stall_if, 1'b0);
    i_if_valid = 1'b0;
    tick();
    chk("lu_add_valid", o_id_valid, 1'b1);
    chk("lu_add_rs", {o_id_rs1, o_id_rs2, o_id_rd}, {5'd2, 5'd2, 5'd3});

    // Flush during a load-use stall.
    do_reset();
    present(32'h0000A103, 64'h4000);
    tick();
    present(32'h002101B3, 64'h4004);
    tick();
    i_flush = 1'b1;
    #1;
    chk("flush_stall_low", o_stall_if, 1'b0);
    tick();
    chk("flush_idex", o_id_valid, 1'b0);
    i_flush = 1'b0;
    i_if_valid = 1'b0;
    tick();
    chk("flush_ifid_empty", o_id_valid, 1'b0);

    // Reset arriving mid-stall.
    do_reset();
    present(32'h0000A103, 64'h5000);
    tick();
    present(32'h002101B3, 64'h5004);
    tick();
    reset = 1'b1;
    #1;
    chk("rst_stall_low", o_stall_if, 1'b0);
    tick();
    reset = 1'b0;
    chk("rst_valid", o_id_valid, 1'b0);
    chk("rst_ctrl", act_ctrl, 8'h00);

    // Writes to x0 are discarded.
    do_reset();
    i_wb_we = 1'b1; i_wb_rd = 5'd0; i_wb_data = 64'hFFFF;
    tick();
    i_wb_we = 1'b0;
    present(32'h000001B3, 64'h6000);
    tick();
    i_if_valid = 1'b0;
    tick();
    chk("x0_rs1", o_id_rs1_data, 64'd0);
    chk("x0_rs2", o_id_rs2_data, 64'd0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 99) < 2);
      i_if_valid = ($urandom_range(0, 3) != 0);
      i_if_pc    = {$urandom, $urandom};
      i_if_instr = rand_instr();
      i_flush    = ($urandom_range(0, 9) == 0);
      i_wb_we    = 1'($urandom_range(0, 1));
      i_wb_rd    = 5'($urandom_range(0, 5));
      i_wb_data  = {$urandom, $urandom};
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
